dreg_bank: RTL and testbench

Parametrised, double-buffered bank of D registers: CH channels of W bits each, written one channel at a time into a shadow copy and committed to the visible outputs atomically on a single pulse. The active registers also support a serial shift mode for test and scan-style loading. It is the clocked, multi-channel successor to the team's single-bit enable/reset storage element. It sits between configuration or bus write logic and datapath blocks that must see all channels change on the same edge.

---
 rtl/dreg_pkg.sv | 13 +
 rtl/dreg_bank_if.sv | 30 +++
 rtl/dreg_cell.sv | 46 ++++
 rtl/dreg_bank.sv | 69 ++++++
 tb/tb_dreg_bank.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/dreg_pkg.sv
// Shared types and helpers for the double-buffered register bank.
package dreg_pkg;

    typedef enum logic {
        SH_LEFT  = 1'b0,
        SH_RIGHT = 1'b1
    } sh_dir_e;

    function automatic int ch_idx_w(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/dreg_bank_if.sv
// Write/commit/shift bus of dreg_bank. All inputs are sampled on the rising clock edge;
// there is no back-pressure: every asserted wr_en/commit/sh_en takes effect at that edge.
interface dreg_bank_if
    import dreg_pkg::*;
#(
    parameter int W  = 8,
    parameter int CH = 4,
    parameter int CW = ch_idx_w(CH)
);
    logic            wr_en;
    logic [CW-1:0]   wr_ch;
    logic [W-1:0]    wr_data;
    logic            commit;
    logic            sh_en;
    logic            sh_dir;
    logic            sh_in;
    logic [CH*W-1:0] q;
    logic [CH-1:0]   dirty;
    logic            sh_out;

    modport master (
        output wr_en, wr_ch, wr_data, commit, sh_en, sh_dir, sh_in,
        input  q, dirty, sh_out
    );

    modport slave (
        input  wr_en, wr_ch, wr_data, commit, sh_en, sh_dir, sh_in,
        output q, dirty, sh_out
    );
endinterface

// File: rtl/dreg_cell.sv
// One channel: shadow register, active register and dirty flag.
module dreg_cell
    import dreg_pkg::*;
#(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr,
    input  logic [W-1:0] wr_data,
    input  logic         commit,
    input  logic         sh_en,
    input  sh_dir_e      sh_dir,
    input  logic         sh_in,
    output logic [W-1:0] q,
    output logic         dirty
);
    logic [W-1:0] shadow;
    logic [W-1:0] shifted;

    // Casts keep the low W bits, so this also holds for W == 1.
    always_comb begin
        shifted = '0;
        if (sh_dir == SH_LEFT) shifted = W'({q, sh_in});
        else                   shifted = W'({sh_in, q} >> 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= RST_VAL;
            q      <= RST_VAL;
            dirty  <= 1'b0;
        end else begin
            if (wr) shadow <= wr_data;
            if (commit) begin
                // Same-edge write bypasses the shadow so it lands in q immediately.
                q     <= wr ? wr_data : shadow;
                dirty <= 1'b0;
            end else begin
                if (wr)    dirty <= 1'b1;
                if (sh_en) q     <= shifted;
            end
        end
    end
endmodule

// File: rtl/dreg_bank.sv
// CH-channel double-buffered register bank with atomic commit and a CH*W-bit scan chain.
module dreg_bank
    import dreg_pkg::*;
#(
    parameter int           W       = 8,
    parameter int           CH      = 4,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input logic         clk,
    input logic         rst,
    dreg_bank_if.slave  bus
);
    localparam int CW = ch_idx_w(CH);

    logic [W-1:0]    cell_q [CH];
    logic            cell_dirty [CH];
    logic [CH*W-1:0] q_flat;
    logic [CH-1:0]   dirty_flat;
    sh_dir_e         dir;

    assign dir = sh_dir_e'(bus.sh_dir);

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic wr_sel;
        logic left_in;
        logic right_in;

        // Indices >= CH never match any channel, so they write nothing.
        assign wr_sel = bus.wr_en && (bus.wr_ch == CW'(c));

        if (c == 0) begin : g_left_head
            assign left_in = bus.sh_in;
        end else begin : g_left_link
            assign left_in = cell_q[c-1][W-1];
        end

        if (c == CH - 1) begin : g_right_head
            assign right_in = bus.sh_in;
        end else begin : g_right_link
            assign right_in = cell_q[c+1][0];
        end

        dreg_cell #(.W(W), .RST_VAL(RST_VAL)) u_cell (
            .clk     (clk),
            .rst     (rst),
            .wr      (wr_sel),
            .wr_data (bus.wr_data),
            .commit  (bus.commit),
            .sh_en   (bus.sh_en),
            .sh_dir  (dir),
            .sh_in   ((dir == SH_RIGHT) ? right_in : left_in),
            .q       (cell_q[c]),
            .dirty   (cell_dirty[c])
        );
    end

    always_comb begin
        q_flat     = '0;
        dirty_flat = '0;
        for (int c = 0; c < CH; c++) begin
            q_flat[c*W +: W] = cell_q[c];
            dirty_flat[c]    = cell_dirty[c];
        end
    end

    assign bus.q      = q_flat;
    assign bus.dirty  = dirty_flat;
    assign bus.sh_out = (dir == SH_RIGHT) ? cell_q[0][0] : cell_q[CH-1][W-1];
endmodule

// File: tb/tb_dreg_bank.sv
// Drives a CH=4 and a CH=3 bank with identical stimulus and checks both against a chain-level model.
module tb_dreg_bank;
    import dreg_pkg::*;

    localparam int         W   = 8;
    localparam logic [7:0] RV4 = 8'hA5;
    localparam logic [7:0] RV3 = 8'h3C;

    typedef struct packed {
        logic       rst;
        logic       wr_en;
        logic [1:0] wr_ch;
        logic [7:0] wr_data;
        logic       commit;
        logic       sh_en;
        logic       sh_dir;
        logic       sh_in;
    } stim_t;

    typedef struct packed {
        logic [3:0][7:0] shadow;
        logic [31:0]     act;
        logic [3:0]      dirty;
    } model_t;

    typedef struct packed {
        logic [31:0] q;
        logic [3:0]  dirty;
        logic        sh_out;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dreg_bank_if #(.W(W), .CH(4)) bus4 ();
    dreg_bank_if #(.W(W), .CH(3)) bus3 ();

    dreg_bank #(.W(W), .CH(4), .RST_VAL(RV4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    dreg_bank #(.W(W), .CH(3), .RST_VAL(RV3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    model_t m4, m3;
    exp_t   exp4_q[$];
    exp_t   exp3_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    // Whole bank treated as one nch*8-bit vector; shadows as an array of bytes.
    function automatic model_t model_next(model_t m, stim_t s, int nch, logic [7:0] rv);
        model_t      n = m;
        int          bits = nch * 8;
        logic [31:0] mask = (bits == 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
        logic        valid = s.wr_en && (int'(s.wr_ch) < nch);
        if (s.rst) begin
            n = '0;
            for (int c = 0; c < nch; c++) begin
                n.shadow[c]   = rv;
                n.act[c*8 +: 8] = rv;
            end
            return n;
        end
        if (valid) n.shadow[s.wr_ch] = s.wr_data;
        if (s.commit) begin
            n.act = '0;
            for (int c = 0; c < nch; c++) n.act[c*8 +: 8] = n.shadow[c];
            n.dirty = '0;
        end else begin
            if (valid) n.dirty[s.wr_ch] = 1'b1;
            if (s.sh_en) begin
                if (!s.sh_dir) n.act = ((m.act << 1) | {31'd0, s.sh_in}) & mask;
                else           n.act = (m.act >> 1) | ({31'd0, s.sh_in} << (bits - 1));
            end
        end
        return n;
    endfunction

    function automatic exp_t make_exp(model_t m, logic dir, int nch);
        exp_t e;
        e.q      = m.act;
        e.dirty  = m.dirty;
        e.sh_out = dir ? m.act[0] : m.act[nch*8-1];
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input stim_t s);
        @(negedge clk);
        rst          = s.rst;
        bus4.wr_en   = s.wr_en;   bus3.wr_en   = s.wr_en;
        bus4.wr_ch   = s.wr_ch;   bus3.wr_ch   = s.wr_ch;
        bus4.wr_data = s.wr_data; bus3.wr_data = s.wr_data;
        bus4.commit  = s.commit;  bus3.commit  = s.commit;
        bus4.sh_en   = s.sh_en;   bus3.sh_en   = s.sh_en;
        bus4.sh_dir  = s.sh_dir;  bus3.sh_dir  = s.sh_dir;
        bus4.sh_in   = s.sh_in;   bus3.sh_in   = s.sh_in;
        m4 = model_next(m4, s, 4, RV4);
        m3 = model_next(m3, s, 3, RV3);
        exp4_q.push_back(make_exp(m4, s.sh_dir, 4));
        exp3_q.push_back(make_exp(m3, s.sh_dir, 3));
    endtask

    function automatic stim_t wr(input logic [1:0] ch, input logic [7:0] d);
        stim_t s = '0;
        s.wr_en = 1'b1; s.wr_ch = ch; s.wr_data = d;
        return s;
    endfunction

    // Monitor: one expected entry per clock edge for each bank.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp4_q.size() > 0) begin
                e = exp4_q.pop_front();
                check("ch4_q",      bus4.q,                e.q);
                check("ch4_dirty",  {28'd0, bus4.dirty},   {28'd0, e.dirty});
                check("ch4_sh_out", {31'd0, bus4.sh_out},  {31'd0, e.sh_out});
            end
            if (exp3_q.size() > 0) begin
                e = exp3_q.pop_front();
                check("ch3_q",      {8'd0, bus3.q},        e.q);
                check("ch3_dirty",  {29'd0, bus3.dirty},   {28'd0, e.dirty});
                check("ch3_sh_out", {31'd0, bus3.sh_out},  {31'd0, e.sh_out});
            end
        end
    end

    initial begin
        stim_t s;
        int    guard;
        m4 = '0;
        m3 = '0;
        rst = 1'b1;
        bus4.wr_en = 0; bus4.wr_ch = 0; bus4.wr_data = 0; bus4.commit = 0;
        bus4.sh_en = 0; bus4.sh_dir = 0; bus4.sh_in = 0;
        bus3.wr_en = 0; bus3.wr_ch = 0; bus3.wr_data = 0; bus3.commit = 0;
        bus3.sh_en = 0; bus3.sh_dir = 0; bus3.sh_in = 0;

        s = '0; s.rst = 1'b1;
        drive(s);
        drive(s);

        drive(wr(2'd2, 8'h3C));
        drive('0);
        s = '0; s.commit = 1'b1;
        drive(s);

        s = wr(2'd1, 8'h77); s.commit = 1'b1;
        drive(s);
        s = '0; s.commit = 1'b1;
        drive(s);

        // Clear every channel; the index-3 write is out of range for the 3-channel bank.
        for (int c = 0; c < 4; c++) drive(wr(2'(c), 8'h00));
        s = '0; s.commit = 1'b1;
        drive(s);

        s = '0; s.sh_en = 1'b1; s.sh_in = 1'b1;
        for (int i = 0; i < 32; i++) drive(s);
        s = '0; s.sh_en = 1'b1; s.sh_dir = 1'b1;
        for (int i = 0; i < 12; i++) drive(s);
        s.sh_in = 1'b1;
        for (int i = 0; i < 5; i++) drive(s);

        drive(wr(2'd0, 8'h81));
        s = '0; s.commit = 1'b1; s.sh_en = 1'b1; s.sh_in = 1'b1;
        drive(s);

        drive(wr(2'd3, 8'hE7));
        drive(wr(2'd0, 8'h11));
        drive(wr(2'd3, 8'h22));
        s = '0; s.rst = 1'b1;
        drive(s);
        s = '0; s.commit = 1'b1;
        drive(s);

        for (int i = 0; i < 600; i++) begin
            s         = '0;
            s.rst     = ($urandom_range(0, 59) == 0);
            s.wr_en   = $urandom_range(0, 1);
            s.wr_ch   = 2'($urandom_range(0, 3));
            s.wr_data = 8'($urandom);
            s.commit  = ($urandom_range(0, 7) == 0);
            s.sh_en   = $urandom_range(0, 1);
            s.sh_dir  = $urandom_range(0, 1);
            s.sh_in   = $urandom_range(0, 1);
            drive(s);
        end
        drive('0);

        guard = 0;
        while ((exp4_q.size() > 0 || exp3_q.size() > 0) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (exp4_q.size() > 0 || exp3_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d/%0d entries left, required 0", exp4_q.size(), exp3_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
